// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving cpu_top's register file and 74181 ALU.
// Keeps a carry flag for branch-on-carry, supports halt, and counts retired instructions.
module cpu_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   alu_cout,
  output logic [2:0]             reg_read_addr1,
  output logic [2:0]             reg_read_addr2,
  output logic                   reg_write_enable,
  output logic [2:0]             reg_write_addr,
  output logic [DATA_WIDTH-1:0]  reg_write_data,
  output logic [3:0]             alu_comm,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic                   b_source_sel,
  output logic [DATA_WIDTH-1:0]  alu_b_imm,
  output logic                   carry_flag,
  output logic                   busy,
  output logic                   halted,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED
  } state_t;

  state_t                  state;
  logic [PC_WIDTH-1:0]     pc;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    carry_q;
  logic                    write_q;
  logic                    busy_q;
  logic                    halted_q;
  logic [15:0]             count_q;
  logic                    unused_reserved;

  // Decode is purely combinational from ir, so it holds steady from EXECUTE through WRITEBACK.
  assign alu_comm       = ir[31:28];
  assign alu_mode       = ir[27];
  assign alu_cin        = ir[26];
  assign b_source_sel   = ir[25];
  assign reg_write_addr = ir[23:21];
  assign reg_read_addr1 = ir[20:18];
  assign reg_read_addr2 = ir[17:15];
  assign alu_b_imm      = {{(DATA_WIDTH-12){ir[11]}}, ir[11:0]};
  assign unused_reserved = ir[12];

  assign imem_addr        = pc;
  assign reg_write_data   = result_q;
  assign reg_write_enable = write_q;
  assign carry_flag       = carry_q;
  assign busy             = busy_q;
  assign halted           = halted_q;
  assign instr_count      = count_q;

  // NOTE: every register here, including the write-enable, sits under the async reset, so
  // asserting reset_n mid-WRITEBACK kills the write strobe without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state    <= FETCH;
            pc       <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= imem_rdata;
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (ir[14]) begin
            state    <= HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (ir[13]) begin
            // Branch target is truncated to the pc width.
            pc      <= carry_q ? ir[PC_WIDTH-1:0] : pc + PC_WIDTH'(1);
            count_q <= count_q + 16'd1;
            state   <= FETCH;
          end else begin
            result_q <= alu_result;
            carry_q  <= alu_cout;
            write_q  <= ir[24];
            state    <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          write_q <= 1'b0;
          pc      <= pc + PC_WIDTH'(1);
          count_q <= count_q + 16'd1;
          state   <= FETCH;
        end
        default: begin
          state    <= IDLE;
          write_q  <= 1'b0;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer that sits directly upstream of cpu_top. It fetches instruction words from a synchronous-read instruction memory and decodes them. It drives cpu_top's register-file addresses and ALU control inputs (74181 comm/mode/cin, B-source select, immediate), then writes the ALU result back through cpu_top's register write port. It keeps a carry flag and supports halt and branch-on-carry.

Parameters:
DATA_WIDTH, 16, datapath width; must match cpu_top.
PC_WIDTH, 8, program counter and instruction-memory address width.
INSTR_WIDTH, 32, instruction word width; the field layout below is fixed for 32 bits.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  run request, sampled in IDLE and HALTED
imem_addr  out  PC_WIDTH  instruction memory address (equals pc)
imem_rdata  in  INSTR_WIDTH  instruction word, valid 1 cycle after imem_addr
alu_result  in  DATA_WIDTH  from cpu_top
alu_cout  in  1  from cpu_top
reg_read_addr1  out  3  ir[20:18] (rs1)
reg_read_addr2  out  3  ir[17:15] (rs2)
reg_write_enable  out  1  high only in WRITEBACK when ir[24]=1
reg_write_addr  out  3  ir[23:21] (rd)
reg_write_data  out  DATA_WIDTH  result_q
alu_comm  out  4  ir[31:28]
alu_mode  out  1  ir[27]
alu_cin  out  1  ir[26]
b_source_sel  out  1  ir[25]
alu_b_imm  out  DATA_WIDTH  ir[11:0] sign-extended to DATA_WIDTH
carry_flag  out  1  latched alu_cout
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  out  1  high in HALTED
instr_count  out  16  count of retired instructions

Behaviour:
- Instruction fields:
  - [31:28] comm, [27] mode, [26] cin, [25] bsel, [24] we
  - [23:21] rd, [20:18] rs1, [17:15] rs2
  - [14] halt, [13] brc, [12] reserved (ignored), [11:0] imm
- Reset (reset_n=0, asynchronous):
  - state=IDLE; pc, ir, result_q, carry_flag, instr_count = 0.
  - All outputs are 0, including reg_write_enable.
  - Release is synchronous to the next clk edge.
- ALU control, address and imm outputs are combinational from the registered ir at all times. They stay stable through EXECUTE and WRITEBACK.
- FSM:
  - IDLE: start=1 -> FETCH with pc=0.
  - FETCH: imem_addr=pc -> DECODE.
  - DECODE: ir <= imem_rdata -> EXECUTE.
  - EXECUTE, checked in priority order:
    - halt=1: no capture, pc unchanged -> HALTED.
    - brc=1: pc <= carry_flag ? imm[PC_WIDTH-1:0] : pc+1; carry_flag unchanged; instr_count+1 -> FETCH.
    - otherwise: result_q <= alu_result, carry_flag <= alu_cout -> WRITEBACK.
  - WRITEBACK: reg_write_enable = ir[24] for exactly this one cycle; pc <= pc+1; instr_count+1 -> FETCH.
  - HALTED: halted=1. start=1 -> FETCH with pc=0; carry_flag and instr_count are kept.
- Timing: ALU instructions take 4 cycles; branch and halt take 3.
- start is ignored while busy. A start held high in IDLE or HALTED is accepted once per entry to that state.
- Wrap-around:
  - pc+1 wraps 2^PC_WIDTH-1 -> 0.
  - A branch target wider than PC_WIDTH is truncated.
  - instr_count wraps FFFF -> 0000.
- reset_n asserted mid-WRITEBACK drops reg_write_enable immediately, with no clock needed.
- carry_flag is updated on every non-branch, non-halt instruction regardless of mode, since logic ops still capture cout.
- A register write and a read of the same register in the following instruction are safe: the write commits at the WRITEBACK edge, before the next EXECUTE.

Test Plan:
1. Reset, then start. Program: imem[0] = ADD r1=r0+imm 5 (comm 1001, mode0, cin0, bsel1, we1); imem[1] = halt. Required: r1=0005; halted=1; instr_count=1; pc=1; a total of 7 cycles from FETCH to HALTED.
2. Carry and branch:
   - r2=r0+imm FFF -> r2=FFFF, carry_flag=0.
   - r3=r2+imm 1 -> r3=0000, carry_flag=1.
   - BRC imm=0x07 -> pc=7.
   - imem[7]=halt -> halted=1.
3. Branch not taken: carry_flag=0 at BRC imm=0x20 located at pc=4 -> next fetch address is 5; no reg_write_enable pulse.
4. Register-source ops: r4=0x1234 and r5=0x00FF (via imm loads). Logic AND (comm 1011, mode1, bsel0, rs1=4, rs2=5, rd=6) -> write data 0034. Subtract (comm 0110, mode0, cin1) r4-r5 -> 1135.
5. Control robustness:
   - start pulsed during EXECUTE -> no effect.
   - reset_n low during WRITEBACK -> reg_write_enable=0 in the same cycle, state IDLE, instr_count=0.
   - start after HALTED restarts at pc=0 with instr_count retained.
6. PC wrap: with PC_WIDTH=8, a non-branch instruction at pc=255 -> next fetch address is 0.
